// File: rtl/vga_capture.sv
// VGA link sink: recovers pixel position from sync edges, verifies frame timing,
// locks onto it and emits one registered write per visible pixel while locked.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 10,
    parameter bit SYNC_POL = 1'b1,
    parameter int PIX_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    output logic        cap_valid,
    output logic [9:0]  cap_x,
    output logic [9:0]  cap_y,
    output logic [18:0] cap_addr,
    output logic [2:0]  cap_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [10:0] line_len
);

    localparam logic signed [12:0] X_OFS = 13'(H_SYNC + H_BP + PIX_LAT);
    localparam logic signed [12:0] X_LIM = 13'(H_ACTIVE);
    localparam logic signed [11:0] Y_OFS = 12'(V_SYNC + V_BP + 1);
    localparam logic signed [11:0] Y_LIM = 12'(V_ACTIVE);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic        h_primed_q, h_primed_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vline_q, vline_d;

    logic        cap_valid_q, cap_valid_d;
    logic [9:0]  cap_x_q, cap_x_d;
    logic [9:0]  cap_y_q, cap_y_d;
    logic [18:0] cap_addr_q, cap_addr_d;
    logic [2:0]  cap_rgb_q, cap_rgb_d;
    logic        frame_start_q, frame_start_d;
    logic        sync_err_q, sync_err_d;
    logic [10:0] line_len_q, line_len_d;

    logic        hs_act, vs_act;
    logic        hs_edge, vs_edge;
    logic [10:0] hcnt_inc, hcnt_tick;
    logic [9:0]  vline_base, vline_tick;
    logic        err_line, err_miss, err_frame, sync_fault;
    logic signed [12:0] x_pos;
    logic signed [11:0] y_pos;
    logic        visible;
    logic [9:0]  x_pix, y_pix;
    logic [18:0] addr_shift, addr_mult;
    logic        capture_en;

    // Sync front end and position counters; everything holds between pixel strobes.
    always_comb begin
        hs_act   = (hsync == SYNC_POL);
        vs_act   = (vsync == SYNC_POL);
        hs_edge  = p_tick && hs_act && !hs_prev_q;
        vs_edge  = p_tick && vs_act && !vs_prev_q;

        hcnt_inc  = (hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1;
        hcnt_tick = hs_edge ? 11'd0 : hcnt_inc;

        vline_base = vs_edge ? 10'd0 : vline_q;
        vline_tick = (hs_edge && (vline_base != 10'h3FF)) ? vline_base + 10'd1 : vline_base;

        hs_prev_d  = p_tick ? hs_act : hs_prev_q;
        vs_prev_d  = p_tick ? vs_act : vs_prev_q;
        h_primed_d = h_primed_q || hs_edge;
        hcnt_d     = p_tick ? hcnt_tick : hcnt_q;
        vline_d    = p_tick ? vline_tick : vline_q;
    end

    // Timing checks; only meaningful once the FSM has seen a vsync edge.
    always_comb begin
        err_line   = hs_edge && h_primed_q && (hcnt_q != 11'(H_TOTAL - 1));
        err_miss   = p_tick && !hs_edge && (hcnt_q == 11'(H_TOTAL - 1));
        err_frame  = vs_edge && (vline_q != 10'(V_TOTAL));
        sync_fault = (state_q != ST_SEARCH) && (err_line || err_miss || err_frame);
    end

    // Position of the colour sampled on this strobe, taken from post-update counts.
    always_comb begin
        x_pos   = $signed({2'b00, hcnt_tick}) - X_OFS;
        y_pos   = $signed({2'b00, vline_tick}) - Y_OFS;
        visible = (x_pos >= 13'sd0) && (x_pos < X_LIM) &&
                  (y_pos >= 12'sd0) && (y_pos < Y_LIM);
        x_pix   = x_pos[9:0];
        y_pix   = y_pos[9:0];
        addr_shift = ({9'd0, y_pix} << 9) + ({9'd0, y_pix} << 7) + {9'd0, x_pix};
        addr_mult  = 19'(y_pix * H_ACTIVE) + {9'd0, x_pix};
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a fault on the same strobe as a vsync edge takes precedence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_SEARCH: if (vs_edge) state_d = ST_TRACK;
            ST_TRACK: begin
                if (sync_fault)   state_d = ST_SEARCH;
                else if (vs_edge) state_d = ST_LOCKED;
            end
            ST_LOCKED: if (sync_fault) state_d = ST_SEARCH;
            default:   state_d = ST_SEARCH;
        endcase
    end

    // State outputs
    always_comb begin
        capture_en = (state_q == ST_LOCKED);
        locked     = (state_q == ST_LOCKED);
    end

    always_comb begin
        cap_valid_d   = p_tick && capture_en && visible;
        cap_x_d       = cap_valid_d ? x_pix : cap_x_q;
        cap_y_d       = cap_valid_d ? y_pix : cap_y_q;
        cap_addr_d    = cap_valid_d ? ((H_ACTIVE == 640) ? addr_shift : addr_mult) : cap_addr_q;
        cap_rgb_d     = cap_valid_d ? rgb : cap_rgb_q;
        frame_start_d = vs_edge;
        sync_err_d    = sync_fault;
        line_len_d    = hs_edge ? hcnt_inc : line_len_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            h_primed_q    <= 1'b0;
            hcnt_q        <= '0;
            vline_q       <= '0;
            cap_valid_q   <= 1'b0;
            cap_x_q       <= '0;
            cap_y_q       <= '0;
            cap_addr_q    <= '0;
            cap_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            line_len_q    <= '0;
        end else begin
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            h_primed_q    <= h_primed_d;
            hcnt_q        <= hcnt_d;
            vline_q       <= vline_d;
            cap_valid_q   <= cap_valid_d;
            cap_x_q       <= cap_x_d;
            cap_y_q       <= cap_y_d;
            cap_addr_q    <= cap_addr_d;
            cap_rgb_q     <= cap_rgb_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
            line_len_q    <= line_len_d;
        end
    end

    assign cap_valid   = cap_valid_q;
    assign cap_x       = cap_x_q;
    assign cap_y       = cap_y_q;
    assign cap_addr    = cap_addr_q;
    assign cap_rgb     = cap_rgb_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;
    assign line_len    = line_len_q;

endmodule
